// File: rtl/dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_unit
// Brief    : MEM-stage load/store unit driving a CSN/WEN/BE/READY data SRAM.
// Revision : 1.0
// ============================================================================
module dmem_access_unit #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    input  logic        REQ_WE,
    input  logic [2:0]  REQ_TYPE,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    output logic        D_MEM_CSN,
    output logic        D_MEM_WEN,
    output logic [3:0]  D_MEM_BE,
    output logic [31:0] D_MEM_ADDR,
    output logic [31:0] D_MEM_DOUT,
    input  logic [31:0] D_MEM_DI,
    input  logic        D_READY,
    output logic        STALL,
    output logic        RESP_VALID,
    output logic [31:0] RESP_DATA,
    output logic        MISALIGNED,
    output logic        TIMEOUT_ERR
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_timeout;
    logic [2:0]       r_type;
    logic [1:0]       r_off;
    logic             r_we;
    logic             r_misal;
    logic             r_tmo;
    logic [31:0]      r_rdata;
    logic             w_misal;
    logic [4:0]       w_shamt;
    logic [3:0]       w_be;
    logic [31:0]      w_dout;
    logic [31:0]      w_rshift;
    logic [31:0]      w_ext;

    // Byte accesses can never be misaligned; halfwords need addr[0]=0.
    always_comb begin
        case (REQ_TYPE[1:0])
            2'b00:   w_misal = 1'b0;
            2'b01:   w_misal = REQ_ADDR[0];
            default: w_misal = |REQ_ADDR[1:0];
        endcase
    end

    assign w_shamt    = {REQ_ADDR[1:0], 3'b000};
    assign w_cnt_next = r_cnt + 1'b1;
    assign w_timeout  = (w_cnt_next == CNT_W'(TIMEOUT));

    always_comb begin
        w_be   = 4'hF;
        w_dout = '0;
        if (REQ_WE) begin
            case (REQ_TYPE[1:0])
                2'b00: begin
                    w_be   = 4'b0001 << REQ_ADDR[1:0];
                    w_dout = {24'h0, REQ_WDATA[7:0]} << w_shamt;
                end
                2'b01: begin
                    w_be   = 4'b0011 << REQ_ADDR[1:0];
                    w_dout = {16'h0, REQ_WDATA[15:0]} << w_shamt;
                end
                default: w_dout = REQ_WDATA;
            endcase
        end
    end

    assign w_rshift = D_MEM_DI >> {r_off, 3'b000};

    always_comb begin
        case (r_type)
            3'b000:  w_ext = {{24{w_rshift[7]}}, w_rshift[7:0]};
            3'b001:  w_ext = {{16{w_rshift[15]}}, w_rshift[15:0]};
            3'b100:  w_ext = {24'h0, w_rshift[7:0]};
            3'b101:  w_ext = {16'h0, w_rshift[15:0]};
            default: w_ext = D_MEM_DI;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        STALL  = 1'b0;
        case (r_state)
            S_IDLE: begin
                STALL = REQ_VALID;
                if (REQ_VALID) begin
                    w_next = w_misal ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                STALL = 1'b1;
                if (D_READY || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt      <= '0;
            r_type     <= 3'b000;
            r_off      <= 2'b00;
            r_we       <= 1'b0;
            r_misal    <= 1'b0;
            r_tmo      <= 1'b0;
            r_rdata    <= '0;
            D_MEM_CSN  <= 1'b1;
            D_MEM_WEN  <= 1'b1;
            D_MEM_BE   <= 4'h0;
            D_MEM_ADDR <= '0;
            D_MEM_DOUT <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (REQ_VALID) begin
                        r_cnt  <= '0;
                        r_type <= REQ_TYPE;
                        r_off  <= REQ_ADDR[1:0];
                        r_we   <= REQ_WE;
                        if (w_misal) begin
                            r_misal <= 1'b1;
                        end else begin
                            D_MEM_CSN  <= 1'b0;
                            D_MEM_WEN  <= ~REQ_WE;
                            D_MEM_ADDR <= {REQ_ADDR[31:2], 2'b00};
                            D_MEM_BE   <= w_be;
                            D_MEM_DOUT <= w_dout;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= w_cnt_next;
                    // READY on the final counted cycle still wins over the timeout.
                    if (D_READY) begin
                        D_MEM_CSN <= 1'b1;
                        D_MEM_BE  <= 4'h0;
                        r_rdata   <= r_we ? 32'h0 : w_ext;
                    end else if (w_timeout) begin
                        D_MEM_CSN <= 1'b1;
                        D_MEM_BE  <= 4'h0;
                        r_tmo     <= 1'b1;
                        r_rdata   <= '0;
                    end
                end
                S_RESP: begin
                    r_cnt   <= '0;
                    r_misal <= 1'b0;
                    r_tmo   <= 1'b0;
                    r_rdata <= '0;
                end
                default: ;
            endcase
        end
    end

    assign RESP_VALID  = (r_state == S_RESP);
    assign RESP_DATA   = r_rdata;
    assign MISALIGNED  = r_misal;
    assign TIMEOUT_ERR = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_access_unit
// Brief    : Directed + randomized bench with a byte-level reference memory.
// Revision : 1.0
// ============================================================================
module tb_dmem_access_unit;

    localparam int TMO = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ_VALID;
    logic        REQ_WE;
    logic [2:0]  REQ_TYPE;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic        D_MEM_CSN;
    logic        D_MEM_WEN;
    logic [3:0]  D_MEM_BE;
    logic [31:0] D_MEM_ADDR;
    logic [31:0] D_MEM_DOUT;
    logic [31:0] D_MEM_DI;
    logic        D_READY;
    logic        STALL;
    logic        RESP_VALID;
    logic [31:0] RESP_DATA;
    logic        MISALIGNED;
    logic        TIMEOUT_ERR;

    int checks   = 0;
    int failures = 0;

    // SRAM model: READY pulses in the lat_cfg-th cycle of CSN low; 0 = never.
    logic [31:0] sram [64];
    int          lat_cfg = 1;
    int          lat_cnt = 0;
    logic        ready_force = 1'b0;
    bit          mem_init;

    // Reference memory, one entry per byte of the 0x100..0x1FF window.
    logic [7:0]  ref_mem [256];

    always #5 CLK = ~CLK;

    assign D_READY  = (!D_MEM_CSN && lat_cfg > 0 && lat_cnt == lat_cfg - 1) || ready_force;
    assign D_MEM_DI = sram[D_MEM_ADDR[7:2]];

    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) sram[i] <= 32'h0;
        end else if (!D_MEM_CSN && D_READY && !D_MEM_WEN) begin
            for (int i = 0; i < 4; i++)
                if (D_MEM_BE[i]) sram[D_MEM_ADDR[7:2]][8*i +: 8] <= D_MEM_DOUT[8*i +: 8];
        end
        if (!D_MEM_CSN && !D_READY) lat_cnt <= lat_cnt + 1;
        else                        lat_cnt <= 0;
    end

    dmem_access_unit #(
        .TIMEOUT (TMO),
        .CNT_W   (4)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .REQ_VALID   (REQ_VALID),
        .REQ_WE      (REQ_WE),
        .REQ_TYPE    (REQ_TYPE),
        .REQ_ADDR    (REQ_ADDR),
        .REQ_WDATA   (REQ_WDATA),
        .D_MEM_CSN   (D_MEM_CSN),
        .D_MEM_WEN   (D_MEM_WEN),
        .D_MEM_BE    (D_MEM_BE),
        .D_MEM_ADDR  (D_MEM_ADDR),
        .D_MEM_DOUT  (D_MEM_DOUT),
        .D_MEM_DI    (D_MEM_DI),
        .D_READY     (D_READY),
        .STALL       (STALL),
        .RESP_VALID  (RESP_VALID),
        .RESP_DATA   (RESP_DATA),
        .MISALIGNED  (MISALIGNED),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full request; expectations come from access size, alignment and ref_mem.
    task automatic access(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                          input logic [31:0] wdata, input int lat, input string tag);
        int          n;
        int          stall_cnt;
        int          csn_cnt;
        logic        mis;
        logic        tmo;
        logic        done;
        logic        seen_csn;
        logic [31:0] mask;
        logic [31:0] val;
        logic [31:0] exp_dout;
        logic [3:0]  exp_be;
        logic [31:0] s_addr;
        logic [31:0] s_dout;
        logic [3:0]  s_be;
        logic        s_wen;

        n    = (typ[1:0] == 2'b00) ? 1 : (typ[1:0] == 2'b01) ? 2 : 4;
        mis  = (addr % n) != 0;
        tmo  = !mis && lat == 0;
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        exp_be   = we ? 4'(((1 << n) - 1) << addr[1:0]) : 4'hF;
        exp_dout = (wdata & mask) << (8 * addr[1:0]);
        val = 32'h0;
        if (!we && !mis && !tmo) begin
            for (int i = 0; i < n; i++) val |= 32'(ref_mem[8'(addr[7:0] + i)]) << (8 * i);
            if (!typ[2] && n < 4 && val[8*n-1]) val |= ~mask;
        end

        lat_cfg   = lat;
        stall_cnt = 0;
        csn_cnt   = 0;
        done      = 1'b0;
        seen_csn  = 1'b0;
        s_addr = '0; s_dout = '0; s_be = '0; s_wen = 1'b1;
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_WE = we; REQ_TYPE = typ; REQ_ADDR = addr; REQ_WDATA = wdata;
        for (int c = 0; c < 100 && !done; c++) begin
            #1;
            if (RESP_VALID) begin
                done = 1'b1;
                chk({tag, " resp_stall"}, 32'(STALL), 32'd0);
                chk({tag, " resp_data"}, RESP_DATA, val);
                chk({tag, " misaligned"}, 32'(MISALIGNED), 32'(mis));
                chk({tag, " timeout_err"}, 32'(TIMEOUT_ERR), 32'(tmo));
            end else begin
                if (STALL) stall_cnt++;
                if (!D_MEM_CSN) begin
                    if (!seen_csn) begin
                        s_addr = D_MEM_ADDR; s_dout = D_MEM_DOUT; s_be = D_MEM_BE; s_wen = D_MEM_WEN;
                    end
                    seen_csn = 1'b1;
                    csn_cnt++;
                end
            end
            @(negedge CLK);
        end
        REQ_VALID = 1'b0;
        chk({tag, " resp_seen"}, 32'(done), 32'd1);
        chk({tag, " stall_cycles"}, 32'(stall_cnt), mis ? 32'd1 : tmo ? 32'(TMO + 1) : 32'(lat + 1));
        chk({tag, " csn_cycles"}, 32'(csn_cnt), mis ? 32'd0 : tmo ? 32'(TMO) : 32'(lat));
        if (!mis) begin
            chk({tag, " mem_addr"}, s_addr, addr & 32'hFFFF_FFFC);
            chk({tag, " mem_wen"}, 32'(s_wen), 32'(!we));
            chk({tag, " mem_be"}, 32'(s_be), 32'(exp_be));
            if (we) chk({tag, " mem_dout"}, s_dout, exp_dout);
        end
        #1;
        chk({tag, " resp_pulse_end"}, 32'(RESP_VALID), 32'd0);
        if (we && !mis && !tmo)
            for (int i = 0; i < n; i++) ref_mem[8'(addr[7:0] + i)] = wdata[8*i +: 8];
    endtask

    initial begin
        logic        we;
        logic [2:0]  typ;
        logic [31:0] addr;
        int          k;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        mem_init = 1'b1;
        RST = 1'b1; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_TYPE = 3'b010;
        REQ_ADDR = '0; REQ_WDATA = '0;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst csn", 32'(D_MEM_CSN), 32'd1);
        chk("rst wen", 32'(D_MEM_WEN), 32'd1);
        chk("rst be", 32'(D_MEM_BE), 32'd0);
        chk("rst addr", D_MEM_ADDR, 32'd0);
        chk("rst dout", D_MEM_DOUT, 32'd0);
        chk("rst resp_valid", 32'(RESP_VALID), 32'd0);
        chk("rst resp_data", RESP_DATA, 32'd0);
        chk("rst flags", {30'd0, MISALIGNED, TIMEOUT_ERR}, 32'd0);
        chk("rst stall", 32'(STALL), 32'd0);
        RST = 1'b0;
        mem_init = 1'b0;

        access(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 2, "sw");
        access(1'b0, 3'b000, 32'h101, 32'h0, 1, "lb");
        access(1'b0, 3'b100, 32'h103, 32'h0, 3, "lbu");
        access(1'b0, 3'b001, 32'h102, 32'h0, 2, "lh");
        access(1'b0, 3'b101, 32'h100, 32'h0, 1, "lhu");
        access(1'b0, 3'b010, 32'h100, 32'h0, 2, "lw");
        access(1'b1, 3'b000, 32'h102, 32'h0000_0055, 2, "sb");
        access(1'b0, 3'b010, 32'h100, 32'h0, 1, "lw_after_sb");
        access(1'b0, 3'b010, 32'h102, 32'h0, 2, "lw_misaligned");
        access(1'b0, 3'b010, 32'h104, 32'h0, 0, "lw_timeout");
        access(1'b0, 3'b010, 32'h100, 32'h0, 2, "lw_after_timeout");

        // Reset lands mid-BUSY, then a stray READY arrives while idle.
        lat_cfg = 6;
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_TYPE = 3'b010; REQ_ADDR = 32'h100;
        repeat (3) @(negedge CLK);
        #1;
        chk("pre_rst busy csn", 32'(D_MEM_CSN), 32'd0);
        RST = 1'b1;
        @(negedge CLK);
        #1;
        chk("mid_rst csn", 32'(D_MEM_CSN), 32'd1);
        chk("mid_rst stall", 32'(STALL), 32'(REQ_VALID));
        chk("mid_rst flags", {29'd0, RESP_VALID, MISALIGNED, TIMEOUT_ERR}, 32'd0);
        RST = 1'b0; REQ_VALID = 1'b0; ready_force = 1'b1;
        @(negedge CLK);
        ready_force = 1'b0;
        #1;
        chk("late_ready resp_valid", 32'(RESP_VALID), 32'd0);
        chk("late_ready csn", 32'(D_MEM_CSN), 32'd1);
        chk("late_ready stall", 32'(STALL), 32'd0);
        access(1'b0, 3'b010, 32'h100, 32'h0, 3, "lw_after_rst");

        for (int t = 0; t < 30; t++) begin
            we = 1'($urandom_range(0, 1));
            if (we) begin
                typ = 3'($urandom_range(0, 2));
            end else begin
                k   = $urandom_range(0, 4);
                typ = (k < 3) ? 3'(k) : 3'(k + 1);
            end
            addr = 32'h100 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            access(we, typ, addr, $urandom, $urandom_range(1, 4), $sformatf("rnd%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
